// File: rtl/line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// line_buffer_ctrl
//
// Sequences four LINE_WIDTH-deep line buffers to build a 3x3 sliding window
// for the Canny front end (Gaussian / Sobel stage).
//
// Incoming pixels are steered round-robin into the four buffers. The
// controller tracks how many pixels are stored. Once three complete lines are
// present, three buffers are read in lockstep for LINE_WIDTH cycles and their
// taps are presented as one 72-bit window.
//
// Ports:
//   clk             clock
//   rst             synchronous, active-high reset
//   pixel_in_valid  upstream pixel strobe (beat = valid && ready)
//   pixel_in_ready  controller can accept a pixel this cycle
//   lb_wr_en[3:0]   one-hot write strobe, bit i -> buffer i in_data_valid
//   lb_rd_en[3:0]   read-advance strobe, bit i -> buffer i read_data
//   lbN_data[23:0]  3-pixel tap of buffer N ({p[n], p[n+1], p[n+2]})
//   window_out[71:0]  {top, mid, bottom} row taps, zero when not valid
//   window_valid    window_out is valid this cycle
//   line_done_intr  one-cycle pulse after the last read beat of a line
//   line_count[15:0]  lines fully read since reset (optional, see below)
//
// Optional feature:
//   Define LB_CTRL_LINE_COUNT_EN to add the line_count output and its counter.
//   Without the macro, that port and its counter do not exist.
//
// The buffers must share rst with this block so that their internal pointers
// realign after a reset that lands mid-line.
// -----------------------------------------------------------------------------
module line_buffer_ctrl #(
  parameter int LINE_WIDTH = 256,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_in_valid,
  output logic        pixel_in_ready,
  output logic [3:0]  lb_wr_en,
  output logic [3:0]  lb_rd_en,
  input  logic [23:0] lb0_data,
  input  logic [23:0] lb1_data,
  input  logic [23:0] lb2_data,
  input  logic [23:0] lb3_data,
  output logic [71:0] window_out,
  output logic        window_valid,
  output logic        line_done_intr
`ifdef LB_CTRL_LINE_COUNT_EN
  ,
  output logic [15:0] line_count
`endif
);

  // Fill needs to hold 4*LINE_WIDTH, so it gets three bits more than a column
  // counter.
  localparam int FILL_W = CNT_W + 3;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LINE_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_READ = FILL_W'(3 * LINE_WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

  // Decodes a 2-bit buffer index into a 4-bit one-hot strobe.
  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    logic [3:0] vec;
    vec      = 4'b0000;
    vec[sel] = 1'b1;
    return vec;
  endfunction

  state_e              state_q, state_d;
  logic [1:0]          wr_sel_q, wr_sel_d;
  logic [1:0]          rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                intr_q, intr_d;

  logic                wr_acc_s;
  logic                rd_beat_s;
  logic                in_read_s;
  logic [1:0]          rd_sel_p1_s;
  logic [1:0]          rd_sel_p2_s;
  logic [23:0]         tap_s [4];

  assign tap_s[0] = lb0_data;
  assign tap_s[1] = lb1_data;
  assign tap_s[2] = lb2_data;
  assign tap_s[3] = lb3_data;

  assign in_read_s   = (state_q == ST_READ);
  assign rd_sel_p1_s = rd_sel_q + 2'd1;
  assign rd_sel_p2_s = rd_sel_q + 2'd2;

  // Backpressure and write strobe. The buffer that is being read, or that is
  // about to be read because three lines are stored, must never be written.
  always_comb begin
    pixel_in_ready = 1'b1;
    if ((wr_sel_q == rd_sel_q) && (in_read_s || (fill_q >= FILL_READ))) begin
      pixel_in_ready = 1'b0;
    end else begin
      pixel_in_ready = 1'b1;
    end
    wr_acc_s = pixel_in_valid && pixel_in_ready;
    if (wr_acc_s) begin
      lb_wr_en = onehot4(wr_sel_q);
    end else begin
      lb_wr_en = 4'b0000;
    end
  end

  // Write column counter and round-robin target buffer.
  always_comb begin
    wr_sel_d = wr_sel_q;
    wr_cnt_d = wr_cnt_q;
    if (wr_acc_s) begin
      if (wr_cnt_q == CNT_LAST) begin
        wr_cnt_d = CNT_ZERO;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_ONE;
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // Read FSM next state. Returning to IDLE always costs one cycle, so two
  // lines are never read back to back.
  always_comb begin
    state_d   = state_q;
    rd_sel_d  = rd_sel_q;
    rd_cnt_d  = rd_cnt_q;
    intr_d    = 1'b0;
    rd_beat_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fill_q >= FILL_READ) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        rd_beat_s = 1'b1;
        if (rd_cnt_q == CNT_LAST) begin
          rd_cnt_d = CNT_ZERO;
          rd_sel_d = rd_sel_q + 2'd1;
          state_d  = ST_IDLE;
          intr_d   = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fill level: a write and a read beat in the same cycle cancel out.
  always_comb begin
    fill_d = fill_q;
    case ({wr_acc_s, rd_beat_s})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  // Read strobes and window mux. The buffer taps are combinational on their
  // read pointers, so the window is valid in the same cycle as the strobe.
  // The window is forced to zero outside READ.
  always_comb begin
    window_out = 72'd0;
    lb_rd_en   = 4'b0000;
    if (in_read_s) begin
      window_out = {tap_s[rd_sel_q], tap_s[rd_sel_p1_s], tap_s[rd_sel_p2_s]};
      lb_rd_en   = onehot4(rd_sel_q) | onehot4(rd_sel_p1_s) | onehot4(rd_sel_p2_s);
    end else begin
      window_out = 72'd0;
      lb_rd_en   = 4'b0000;
    end
  end

  assign window_valid   = in_read_s;
  assign line_done_intr = intr_q;

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_sel_q <= 2'd0;
      rd_sel_q <= 2'd0;
      wr_cnt_q <= CNT_ZERO;
      rd_cnt_q <= CNT_ZERO;
      fill_q   <= {FILL_W{1'b0}};
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      fill_q   <= fill_d;
      intr_q   <= intr_d;
    end
  end

`ifdef LB_CTRL_LINE_COUNT_EN
  logic [15:0] line_count_q;

  // Completed-line counter. It steps on the same edge that raises
  // line_done_intr, so the two are visible together. It wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_count_q <= 16'd0;
    end else if (intr_d) begin
      line_count_q <= line_count_q + 16'd1;
    end else begin
      line_count_q <= line_count_q;
    end
  end

  assign line_count = line_count_q;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_ctrl
//
// Self-checking bench for line_buffer_ctrl with LINE_WIDTH = 8.
//
// A tiny buffer stand-in remembers, per buffer, the line index of the last
// pixel written into it. Each tap therefore reads {v, v, v}, and the window
// rows identify which buffers are being muxed.
//
// Inputs are driven one tick after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_line_buffer_ctrl;

  localparam int LW = 8;
  localparam int CW = 3;

  localparam logic [71:0] WIN_A = 72'h000000_010101_020202;
  localparam logic [71:0] WIN_B = 72'h010101_020202_030303;
  localparam logic [71:0] WIN_C = 72'h020202_030303_040404;

  logic        clk;
  logic        rst;
  logic        pixel_in_valid;
  logic        pixel_in_ready;
  logic [3:0]  lb_wr_en;
  logic [3:0]  lb_rd_en;
  logic [23:0] lb0_data, lb1_data, lb2_data, lb3_data;
  logic [71:0] window_out;
  logic        window_valid;
  logic        line_done_intr;
`ifdef LB_CTRL_LINE_COUNT_EN
  logic [15:0] line_count;
`endif

  line_buffer_ctrl #(.LINE_WIDTH(LW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_in_valid (pixel_in_valid),
    .pixel_in_ready (pixel_in_ready),
    .lb_wr_en       (lb_wr_en),
    .lb_rd_en       (lb_rd_en),
    .lb0_data       (lb0_data),
    .lb1_data       (lb1_data),
    .lb2_data       (lb2_data),
    .lb3_data       (lb3_data),
    .window_out     (window_out),
    .window_valid   (window_valid),
    .line_done_intr (line_done_intr)
`ifdef LB_CTRL_LINE_COUNT_EN
    ,
    .line_count     (line_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer stand-in: strobes are sampled at the falling edge and applied at
  // the rising edge, which avoids a race with the DUT's own registers.
  logic [7:0] buf_val [4];
  logic [3:0] wr_en_smp;
  logic       rst_smp;
  int         wr_beats;

  always @(negedge clk) begin
    wr_en_smp <= lb_wr_en;
    rst_smp   <= rst;
  end

  always @(posedge clk) begin
    if (rst_smp === 1'b1) begin
      for (int i = 0; i < 4; i++) buf_val[i] <= 8'd0;
      wr_beats <= 0;
    end else if (wr_en_smp !== 4'b0000 && wr_en_smp !== 4'bxxxx) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en_smp[i]) buf_val[i] <= 8'(wr_beats / LW);
      end
      wr_beats <= wr_beats + 1;
    end
  end

  assign lb0_data = {3{buf_val[0]}};
  assign lb1_data = {3{buf_val[1]}};
  assign lb2_data = {3{buf_val[2]}};
  assign lb3_data = {3{buf_val[3]}};

  typedef struct {
    logic        valid;
    logic        ready;
    logic [3:0]  wr;
    logic [3:0]  rd;
    logic        wv;
    logic        intr;
    logic [71:0] win;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input int n, input logic valid, input logic ready, input logic [3:0] wr,
                     input logic [3:0] rd, input logic wv, input logic intr, input logic [71:0] win);
    vec_t v;
    v.valid = valid; v.ready = ready; v.wr = wr; v.rd = rd;
    v.wv = wv; v.intr = intr; v.win = win;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pixel_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lc_exp;
    int intr_seen;
    rst = 1'b1;
    pixel_in_valid = 1'b0;

    // Continuous stream from reset: three line fills, then reads of three
    // lines interleaved with further writes.
    add(8, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 72'd0);   // c0-7
    add(8, 1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 72'd0);   // c8-15
    add(8, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 72'd0);   // c16-23
    add(1, 1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 72'd0);   // c24 fill hits 24
    add(7, 1'b1, 1'b1, 4'b1000, 4'b0111, 1'b1, 1'b0, WIN_A);   // c25-31
    add(1, 1'b1, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0, WIN_A);   // c32 wr_sel==rd_sel
    add(1, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 72'd0);   // c33 intr
    add(7, 1'b1, 1'b1, 4'b0001, 4'b1110, 1'b1, 1'b0, WIN_B);   // c34-40
    add(1, 1'b1, 1'b0, 4'b0000, 4'b1110, 1'b1, 1'b0, WIN_B);   // c41
    add(1, 1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 72'd0);   // c42 intr
    add(7, 1'b1, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, WIN_C);   // c43-49
    add(1, 1'b1, 1'b0, 4'b0000, 4'b1101, 1'b1, 1'b0, WIN_C);   // c50
    add(1, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 72'd0);   // c51 intr

    do_reset();
    @(negedge clk);
    chk("reset ready", 72'(pixel_in_ready), 72'(1'b1));
    chk("reset wr_en", 72'(lb_wr_en), 72'(4'b0000));
    chk("reset rd_en", 72'(lb_rd_en), 72'(4'b0000));
    chk("reset window_valid", 72'(window_valid), 72'(1'b0));
    chk("reset intr", 72'(line_done_intr), 72'(1'b0));
    chk("reset window", window_out, 72'd0);
`ifdef LB_CTRL_LINE_COUNT_EN
    chk("reset line_count", 72'(line_count), 72'(16'd0));
`endif
    next_cycle();

    // Table run.
    do_reset();
    lc_exp = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      pixel_in_valid = vecs[i].valid;
      @(negedge clk);
      chk($sformatf("c%0d ready", i), 72'(pixel_in_ready), 72'(vecs[i].ready));
      chk($sformatf("c%0d wr_en", i), 72'(lb_wr_en), 72'(vecs[i].wr));
      chk($sformatf("c%0d rd_en", i), 72'(lb_rd_en), 72'(vecs[i].rd));
      chk($sformatf("c%0d window_valid", i), 72'(window_valid), 72'(vecs[i].wv));
      chk($sformatf("c%0d intr", i), 72'(line_done_intr), 72'(vecs[i].intr));
      chk($sformatf("c%0d window", i), window_out, vecs[i].win);
`ifdef LB_CTRL_LINE_COUNT_EN
      if (vecs[i].intr) lc_exp++;
      chk($sformatf("c%0d line_count", i), 72'(line_count), 72'(lc_exp));
`endif
      next_cycle();
    end
    pixel_in_valid = 1'b0;

    // Fill accounting: writes during the first read hold fill constant. After
    // 4 lines written and 2 lines read, 16 pixels remain.
    do_reset();
    for (int c = 0; c < 32; c++) begin
      pixel_in_valid = 1'b1;
      @(negedge clk);
      if (c >= 25) chk($sformatf("fill hold c%0d", c), 72'(dut.fill_q), 72'(25));
      next_cycle();
    end
    pixel_in_valid = 1'b0;
    intr_seen = 0;
    for (int c = 0; c < 60 && intr_seen < 2; c++) begin
      @(negedge clk);
      if (line_done_intr === 1'b1) intr_seen++;
      if (intr_seen < 2) next_cycle();
    end
    chk("two lines read before timeout", 72'(intr_seen), 72'(2));
    chk("fill after 4 written 2 read", 72'(dut.fill_q), 72'(16));
    next_cycle();

    // Reset while reading with rd_cnt == 3.
    do_reset();
    for (int c = 0; c < 28; c++) begin
      pixel_in_valid = (c < 24) ? 1'b1 : 1'b0;
      next_cycle();
    end
    rst = 1'b1;                       // cycle 28: READ beat with rd_cnt == 3
    pixel_in_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset window_valid", 72'(window_valid), 72'(1'b1));
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid-read rst ready", 72'(pixel_in_ready), 72'(1'b1));
    chk("mid-read rst wr_en", 72'(lb_wr_en), 72'(4'b0000));
    chk("mid-read rst rd_en", 72'(lb_rd_en), 72'(4'b0000));
    chk("mid-read rst window_valid", 72'(window_valid), 72'(1'b0));
    chk("mid-read rst intr", 72'(line_done_intr), 72'(1'b0));
    chk("mid-read rst window", window_out, 72'd0);
`ifdef LB_CTRL_LINE_COUNT_EN
    chk("mid-read rst line_count", 72'(line_count), 72'(16'd0));
`endif
    next_cycle();

    // Restart: 23 pixels must not start a read; the 24th does, two cycles later.
    for (int c = 0; c < 23; c++) begin
      pixel_in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("restart px%0d window_valid", c), 72'(window_valid), 72'(1'b0));
      next_cycle();
    end
    pixel_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("restart idle%0d window_valid", c), 72'(window_valid), 72'(1'b0));
      next_cycle();
    end
    pixel_in_valid = 1'b1;
    @(negedge clk);
    chk("restart px23 ready", 72'(pixel_in_ready), 72'(1'b1));
    chk("restart px23 window_valid", 72'(window_valid), 72'(1'b0));
    next_cycle();
    pixel_in_valid = 1'b0;
    @(negedge clk);
    chk("restart +1 window_valid", 72'(window_valid), 72'(1'b0));
    next_cycle();
    @(negedge clk);
    chk("restart +2 window_valid", 72'(window_valid), 72'(1'b1));
    chk("restart +2 rd_en", 72'(lb_rd_en), 72'(4'b0111));
    chk("restart +2 window", window_out, WIN_A);
    next_cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
